s2p_deser: RTL and testbench
============================

// Module: s2p_deser
// PURPOSE
//  Parametrised serial-to-parallel deserialiser: shifts qualified serial bits into a DATA_W word.
//  Supports LSB- or MSB-first order and word resync on sync_i.
//  Presents each word on a valid/ready output register, with drop-and-flag overflow.
//  Sits between a bit-level receiver (line decoder/UART-style front end) and word-level consumers.
// PARAMETERS
//  DATA_W     8  word width in bits (legal >= 2)
//  MSB_FIRST  0  0: first bit received lands in data_o[0]; 1: first bit lands in data_o[DATA_W-1]
//  PARITY_ODD 0  parity sense when S2P_PARITY_EN is defined; 0 = even, 1 = odd; ignored otherwise
// PORTS
//  clk          in   1       single clock, all logic on rising edge
//  rst          in   1       synchronous, active-high reset
//  serial_i     in   1       serial data bit
//  valid_i      in   1       serial_i qualifier; one bit consumed per cycle with valid_i=1
//  sync_i       in   1       with valid_i=1: this bit is bit 0 of a new word; partial word discarded
//  data_o       out  DATA_W  assembled word, stable while valid_o=1
//  valid_o      out  1       output word available
//  ready_i      in   1       consumer accepts; transfer when valid_o & ready_i
//  overflow_o   out  1       1-cycle pulse: completed word dropped because output register full
//  parity_err_o out  1       1-cycle pulse with the word's valid_o rise on parity mismatch; const 0 without macro
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): data_o=0, valid_o=0, overflow_o=0, parity_err_o=0,
//    shift register=0, bit counter=0, FSM=COLLECT. A partial word or held output is discarded.
//  - Bit counter is $clog2(DATA_W) bits wide.
//    It increments only on valid_i=1; wrap is explicit (DATA_W-1 -> 0), never relies on 2^n overflow.
//  - Shift, LSB-first: sr <= {serial_i, sr[DATA_W-1:1]}. Shift, MSB-first: sr <= {sr[DATA_W-2:0], serial_i}.
//  - sync_i & valid_i: sr restarts with this bit, counter set to 1.
//    If DATA_W bits have not yet been collected, no word is produced for the discarded partial word.
//  - FSM states (from package): COLLECT, PARITY. PARITY exists only with S2P_PARITY_EN.
//  - Completion = the valid_i cycle carrying the DATA_W-th bit (COLLECT) or the parity bit (PARITY).
//    On the completion edge the word moves into the output register; valid_o=1 from the next cycle.
//    Latency: last data/parity bit sampled at edge N -> valid_o=1 after edge N.
//  - Output register load rule at completion:
//    loads if valid_o=0, or if valid_o & ready_i in the same cycle (back-to-back, no bubble).
//  - Overflow: completion while valid_o=1 & ready_i=0.
//    New word dropped, held word kept unchanged, overflow_o=1 for one cycle, counter restarts at 0.
//  - Acceptance: valid_o & ready_i with no completion -> valid_o=0 next cycle; data_o holds its last value.
//  - valid_o never drops without ready_i (AXI-style stability); data_o never changes while valid_o=1 & !ready_i.
//  - ready_i is ignored while valid_o=0. valid_i=0 cycles freeze the counter and shift register.
// CONFIGURATION
//  S2P_PARITY_EN defined:
//    - After DATA_W data bits, FSM enters PARITY; the next valid_i bit is the parity bit.
//    - Check: (^word ^ parity_bit) must equal PARITY_ODD. On mismatch, the word is still delivered
//      and parity_err_o pulses 1 cycle, aligned with valid_o going high for that word.
//    - sync_i during PARITY restarts the word in COLLECT; the pending word is discarded.
//  S2P_PARITY_EN undefined:
//    - Completion occurs on the DATA_W-th bit, with no PARITY state; parity_err_o is tied 0.
// STRUCTURE
//  - Package s2p_pkg: typedef enum logic [0:0] {COLLECT, PARITY} s2p_state_e;
//    function s2p_cnt_w(DATA_W) returning counter width.
//  - Sub-module s2p_out_reg: single-entry valid/ready holding register with parameter DATA_W.
//    Ports: load_i, data_i, ready_i, data_o, valid_o, full_o (full_o = valid_o & ~ready_i).
//    Top asserts overflow when completion & full_o.
//  - Top contains shift register, counter, FSM and parity accumulator.
// TESTING
//  1 Reset mid-word: DATA_W=8, 5 bits in, rst=1 for 1 cycle, then 8 bits 0xA5 LSB-first
//    -> single valid_o with data_o=0xA5; no word from the partial bits.
//  2 Order: MSB_FIRST=1, bits 1,0,1,0,0,1,0,1 -> data_o=0xA5.
//    Same stream with MSB_FIRST=0 -> data_o=0xA5 reversed, i.e. 0xA5 (palindrome).
//    Also stream 1,0,0,0,0,0,0,0 -> 0x80 (MSB) vs 0x01 (LSB).
//  3 Back-to-back with gaps: ready_i=1, 0x3C then 0xC3, valid_i toggling 1/0
//    -> two transfers, each valid_o 1 cycle after its 8th bit, correct values.
//  4 Overflow: ready_i=0, send 0x11 then 0x22 -> valid_o held with 0x11, overflow_o pulse on 0x22's 8th bit;
//    then ready_i=1 -> 0x11 accepted, valid_o=0.
//  5 Resync: 3 bits, then sync_i=1 with the first bit of 0x5A -> data_o=0x5A after 8 bits from the sync bit.
//  6 S2P_PARITY_EN, PARITY_ODD=0: 0x07 + parity 1 -> parity_err_o=0; 0x07 + parity 0 -> parity_err_o=1,
//    data_o=0x07. DATA_W=16 rerun of tests 1-4.

Source files
------------

// File: rtl/s2p_deser_pkg.sv
// Package s2p_pkg: shared types and helpers for the s2p_deser serial-to-parallel block.
//   s2p_state_e : collector FSM states (PARITY is only reachable when S2P_PARITY_EN is defined)
//   s2p_cnt_w   : bit-counter width for a given word width
package s2p_pkg;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    PARITY  = 1'b1
  } s2p_state_e;

  // Counter must index bit positions 0..data_w-1; keep at least one bit.
  function automatic int unsigned s2p_cnt_w(input int unsigned data_w);
    return (data_w < 2) ? 1 : $clog2(data_w);
  endfunction

endpackage

// File: rtl/s2p_deser_if.sv
// Interface s2p_deser_if: serial input stream plus word-level valid/ready output of s2p_deser.
//   serial_i, valid_i, sync_i : qualified serial bits, sync_i marks bit 0 of a new word
//   data_o, valid_o, ready_i   : word output handshake
//   overflow_o, parity_err_o   : one-cycle event pulses
// Modports: slave  = deserialiser side (consumes bits, produces words)
//           master = environment side (bit source and word consumer)
interface s2p_deser_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic              serial_i;
  logic              valid_i;
  logic              sync_i;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              ready_i;
  logic              overflow_o;
  logic              parity_err_o;

  modport slave (
    input  serial_i, valid_i, sync_i, ready_i,
    output data_o, valid_o, overflow_o, parity_err_o
  );

  modport master (
    output serial_i, valid_i, sync_i, ready_i,
    input  data_o, valid_o, overflow_o, parity_err_o
  );

endinterface

// File: rtl/s2p_deser_out_reg.sv
// s2p_out_reg: single-entry valid/ready holding register.
//   clk, rst : clock, synchronous active-high reset
//   load_i   : capture data_i (caller only loads when not full)
//   data_i   : word to capture
//   ready_i  : consumer accepts the held word
//   data_o   : held word, stable while valid_o & ~ready_i
//   valid_o  : word held
//   full_o   : held word will still be held next cycle (valid_o & ~ready_i)
module s2p_out_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              full_o
);

  // Load wins over acceptance so a word handed off this cycle is replaced without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else if (load_i) begin
      data_o  <= data_i;
      valid_o <= 1'b1;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

  assign full_o = valid_o & ~ready_i;

endmodule

// File: rtl/s2p_deser.sv
// s2p_deser: shifts qualified serial bits into a DATA_W word and presents it on a valid/ready register.
//   clk, rst : clock, synchronous active-high reset
//   bus      : s2p_deser_if.slave (serial_i/valid_i/sync_i in, data_o/valid_o/ready_i word handshake,
//              overflow_o and parity_err_o pulses)
// Parameters: DATA_W (>= 2), MSB_FIRST (first bit lands in data_o[DATA_W-1]), PARITY_ODD (parity sense).
// Build option: define S2P_PARITY_EN to expect a parity bit after each word and flag mismatches;
// without it, parity_err_o is tied low.
module s2p_deser
  import s2p_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter bit          MSB_FIRST  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  s2p_deser_if.slave   bus
);

  localparam int unsigned       CNT_W    = s2p_cnt_w(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] sr_shift;
  logic [DATA_W-1:0] sr_restart;
  logic [DATA_W-1:0] word_c;
  logic [CNT_W-1:0]  cnt;
  logic              complete_c;
  logic              full;
  logic              load;
  logic              overflow_q;

  // Next shift-register value for a normal bit and for a sync bit (restart from an empty word).
  always_comb begin
    sr_shift   = MSB_FIRST ? {sr[DATA_W-2:0], bus.serial_i} : {bus.serial_i, sr[DATA_W-1:1]};
    sr_restart = MSB_FIRST ? {{(DATA_W-1){1'b0}}, bus.serial_i} : {bus.serial_i, {(DATA_W-1){1'b0}}};
  end

`ifdef S2P_PARITY_EN
  s2p_state_e state;
  logic       par_bad_c;
  logic       parity_err_q;

  // Word is already complete in sr; the parity bit finishes it.
  always_comb begin
    complete_c = bus.valid_i & ~bus.sync_i & (state == PARITY);
    word_c     = sr;
    par_bad_c  = ((^sr) ^ bus.serial_i) != PARITY_ODD;
  end

  // Flag only travels with a word that is actually presented, not with a dropped one.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= complete_c & ~full & par_bad_c;
    end
  end

  assign bus.parity_err_o = parity_err_q;
`else
  // Completing bit is the DATA_W-th data bit; the word includes it.
  always_comb begin
    complete_c = bus.valid_i & ~bus.sync_i & (cnt == CNT_LAST);
    word_c     = sr_shift;
  end

  // Parity sense has no effect without the check.
  assign bus.parity_err_o = PARITY_ODD & 1'b0;
`endif

  // Shift register, bit counter and collector FSM; sync takes priority over completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr         <= '0;
      cnt        <= '0;
      overflow_q <= 1'b0;
`ifdef S2P_PARITY_EN
      state      <= COLLECT;
`endif
    end else begin
      overflow_q <= complete_c & full;
      if (bus.valid_i) begin
        if (bus.sync_i) begin
          sr    <= sr_restart;
          cnt   <= CNT_W'(1);
`ifdef S2P_PARITY_EN
          state <= COLLECT;
        end else if (state == PARITY) begin
          state <= COLLECT;
          cnt   <= '0;
`endif
        end else begin
          sr <= sr_shift;
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
`ifdef S2P_PARITY_EN
            state <= PARITY;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      end
    end
  end

  assign load           = complete_c & ~full;
  assign bus.overflow_o = overflow_q;

  s2p_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .data_i  (word_c),
    .ready_i (bus.ready_i),
    .data_o  (bus.data_o),
    .valid_o (bus.valid_o),
    .full_o  (full)
  );

endmodule

// File: tb/tb_s2p_deser.sv
// Testbench for s2p_deser: three instances (8-bit LSB-first, 8-bit MSB-first, 16-bit LSB-first)
// share one serial stream; a bit-list model predicts every output each cycle, and directed
// literal checks pin both the DUTs and the model at key points.
module tb_s2p_deser;

`ifdef S2P_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam bit PAR_ODD = 1'b0;

  logic clk = 1'b0;
  logic rst_r = 1'b1;
  logic serial_r = 1'b0;
  logic valid_r = 1'b0;
  logic sync_r = 1'b0;
  logic ready_r = 1'b1;
  bit   armed = 1'b0;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  s2p_deser_if #(.DATA_W(8))  if0 ();
  s2p_deser_if #(.DATA_W(8))  if1 ();
  s2p_deser_if #(.DATA_W(16)) if2 ();

  assign if0.serial_i = serial_r;
  assign if0.valid_i  = valid_r;
  assign if0.sync_i   = sync_r;
  assign if0.ready_i  = ready_r;
  assign if1.serial_i = serial_r;
  assign if1.valid_i  = valid_r;
  assign if1.sync_i   = sync_r;
  assign if1.ready_i  = ready_r;
  assign if2.serial_i = serial_r;
  assign if2.valid_i  = valid_r;
  assign if2.sync_i   = sync_r;
  assign if2.ready_i  = ready_r;

  s2p_deser #(.DATA_W(8), .MSB_FIRST(1'b0), .PARITY_ODD(PAR_ODD)) dut0 (.clk(clk), .rst(rst_r), .bus(if0));
  s2p_deser #(.DATA_W(8), .MSB_FIRST(1'b1), .PARITY_ODD(PAR_ODD)) dut1 (.clk(clk), .rst(rst_r), .bus(if1));
  s2p_deser #(.DATA_W(16), .MSB_FIRST(1'b0), .PARITY_ODD(PAR_ODD)) dut2 (.clk(clk), .rst(rst_r), .bus(if2));

  logic [15:0] act_d [3];
  logic        act_v [3];
  logic        act_o [3];
  logic        act_p [3];

  assign act_d[0] = 16'(if0.data_o);
  assign act_d[1] = 16'(if1.data_o);
  assign act_d[2] = if2.data_o;
  assign act_v[0] = if0.valid_o;
  assign act_v[1] = if1.valid_o;
  assign act_v[2] = if2.valid_o;
  assign act_o[0] = if0.overflow_o;
  assign act_o[1] = if1.overflow_o;
  assign act_o[2] = if2.overflow_o;
  assign act_p[0] = if0.parity_err_o;
  assign act_p[1] = if1.parity_err_o;
  assign act_p[2] = if2.parity_err_o;

  // ---------------- model: list of received bits per instance ----------------
  int          wd     [3] = '{8, 8, 16};
  bit          msb_of [3] = '{1'b0, 1'b1, 1'b0};
  logic [15:0] rxb    [3];
  int          nb     [3];
  bit          ppend  [3];
  logic [15:0] mword  [3];
  bit          ev     [3];
  logic [15:0] ed     [3];
  bit          eo     [3];
  bit          ep     [3];
  bit          m_done, m_bad, m_acc;
  logic [15:0] m_word;

  // Bit i of the received list is the i-th bit on the wire.
  function automatic logic [15:0] assemble(input logic [15:0] bits, input int n, input bit msb);
    logic [15:0] w = '0;
    for (int i = 0; i < n; i++) begin
      if (msb) w[n-1-i] = bits[i];
      else     w[i]     = bits[i];
    end
    return w;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst_r) begin
        rxb[k] = '0; nb[k] = 0; ppend[k] = 1'b0; mword[k] = '0;
        ev[k] = 1'b0; ed[k] = '0; eo[k] = 1'b0; ep[k] = 1'b0;
      end else begin
        eo[k] = 1'b0; ep[k] = 1'b0;
        m_done = 1'b0; m_bad = 1'b0; m_word = '0;
        m_acc = ev[k] && ready_r;
        if (valid_r) begin
          if (sync_r) begin
            rxb[k] = '0; rxb[k][0] = serial_r; nb[k] = 1; ppend[k] = 1'b0;
          end else if (ppend[k]) begin
            ppend[k] = 1'b0;
            m_done = 1'b1;
            m_word = mword[k];
            m_bad = (($countones(m_word) + int'(serial_r)) % 2) != int'(PAR_ODD);
          end else begin
            rxb[k][nb[k]] = serial_r;
            nb[k]++;
            if (nb[k] == wd[k]) begin
              nb[k] = 0;
              m_word = assemble(rxb[k], wd[k], msb_of[k]);
              if (PAR_EN) begin ppend[k] = 1'b1; mword[k] = m_word; end
              else m_done = 1'b1;
            end
          end
        end
        if (m_done) begin
          if (ev[k] && !ready_r) eo[k] = 1'b1;
          else begin ev[k] = 1'b1; ed[k] = m_word; ep[k] = m_bad; end
        end else if (m_acc) begin
          ev[k] = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("valid_o[%0d]", k), 16'(act_v[k]), 16'(ev[k]));
        chk($sformatf("data_o[%0d]", k), act_d[k], ed[k]);
        chk($sformatf("overflow_o[%0d]", k), 16'(act_o[k]), 16'(eo[k]));
        chk($sformatf("parity_err_o[%0d]", k), 16'(act_p[k]), 16'(ep[k]));
      end
    end
  end

  // Literal expectation checked against both the DUT and the model.
  task automatic lit(input string name, input logic [15:0] act, input logic [15:0] mdl, input logic [15:0] exp);
    chk({name, " dut"}, act, exp);
    chk({name, " model"}, mdl, exp);
  endtask

  // ---------------- stimulus ----------------
  task automatic cyc(input logic s, input logic v, input logic sy);
    serial_r = s; valid_r = v; sync_r = sy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_r = 1'b1;
    idle();
    rst_r = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] val, input int n, input bit sync_first,
                           input bit gap, input bit bad_par);
    logic p;
    p = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gap && i > 0) idle();
      cyc(val[i], 1'b1, sync_first && (i == 0));
      p = p ^ val[i];
    end
    if (PAR_EN) begin
      if (gap) idle();
      cyc(p ^ PAR_ODD ^ bad_par, 1'b1, 1'b0);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    armed = 1'b1;

    // Reset state
    for (int k = 0; k < 3; k++) begin
      lit($sformatf("rst valid[%0d]", k), 16'(act_v[k]), 16'(ev[k]), 16'h0);
      lit($sformatf("rst data[%0d]", k), act_d[k], ed[k], 16'h0);
      lit($sformatf("rst ovf[%0d]", k), 16'(act_o[k]), 16'(eo[k]), 16'h0);
    end

    // 1: reset mid-word
    ready_r = 1'b1;
    cyc(1, 1, 0); cyc(1, 1, 0); cyc(0, 1, 0); cyc(1, 1, 0); cyc(1, 1, 0);
    do_reset();
    lit("t1 valid before", 16'(act_v[0]), 16'(ev[0]), 16'h0);
    send_word(16'h00A5, 8, 1'b0, 1'b0, 1'b0);
    lit("t1 valid", 16'(act_v[0]), 16'(ev[0]), 16'h1);
    lit("t1 data", act_d[0], ed[0], 16'h00A5);

    // 2: bit order
    do_reset();
    send_word(16'h00A5, 8, 1'b0, 1'b0, 1'b0);
    lit("t2 lsb A5", act_d[0], ed[0], 16'h00A5);
    lit("t2 msb A5", act_d[1], ed[1], 16'h00A5);
    send_word(16'h0001, 8, 1'b0, 1'b0, 1'b0);
    lit("t2 lsb 01", act_d[0], ed[0], 16'h0001);
    lit("t2 msb 80", act_d[1], ed[1], 16'h0080);

    // 3: back-to-back with gaps
    do_reset();
    send_word(16'h003C, 8, 1'b0, 1'b1, 1'b0);
    lit("t3 valid 3C", 16'(act_v[0]), 16'(ev[0]), 16'h1);
    lit("t3 data 3C", act_d[0], ed[0], 16'h003C);
    idle();
    lit("t3 accepted", 16'(act_v[0]), 16'(ev[0]), 16'h0);
    send_word(16'h00C3, 8, 1'b0, 1'b1, 1'b0);
    lit("t3 data C3", act_d[0], ed[0], 16'h00C3);

    // 4: overflow
    do_reset();
    ready_r = 1'b0;
    send_word(16'h0011, 8, 1'b0, 1'b0, 1'b0);
    lit("t4 data 11", act_d[0], ed[0], 16'h0011);
    send_word(16'h0022, 8, 1'b0, 1'b0, 1'b0);
    lit("t4 ovf", 16'(act_o[0]), 16'(eo[0]), 16'h1);
    lit("t4 held 11", act_d[0], ed[0], 16'h0011);
    ready_r = 1'b1;
    idle();
    lit("t4 accepted", 16'(act_v[0]), 16'(ev[0]), 16'h0);
    lit("t4 ovf end", 16'(act_o[0]), 16'(eo[0]), 16'h0);

    // 5: resync
    do_reset();
    cyc(1, 1, 0); cyc(1, 1, 0); cyc(1, 1, 0);
    send_word(16'h005A, 8, 1'b1, 1'b0, 1'b0);
    lit("t5 data 5A", act_d[0], ed[0], 16'h005A);

    // 16-bit reruns
    do_reset();
    cyc(1, 1, 0); cyc(0, 1, 0); cyc(1, 1, 0); cyc(1, 1, 0); cyc(1, 1, 0);
    do_reset();
    send_word(16'hBEEF, 16, 1'b0, 1'b0, 1'b0);
    lit("w16 data BEEF", act_d[2], ed[2], 16'hBEEF);
    idle();
    lit("w16 accepted", 16'(act_v[2]), 16'(ev[2]), 16'h0);
    send_word(16'h3C3C, 16, 1'b0, 1'b1, 1'b0);
    lit("w16 data 3C3C", act_d[2], ed[2], 16'h3C3C);
    send_word(16'hC3C3, 16, 1'b0, 1'b1, 1'b0);
    lit("w16 data C3C3", act_d[2], ed[2], 16'hC3C3);
    idle();
    ready_r = 1'b0;
    send_word(16'h1111, 16, 1'b0, 1'b0, 1'b0);
    lit("w16 data 1111", act_d[2], ed[2], 16'h1111);
    send_word(16'h2222, 16, 1'b0, 1'b0, 1'b0);
    lit("w16 ovf", 16'(act_o[2]), 16'(eo[2]), 16'h1);
    lit("w16 held 1111", act_d[2], ed[2], 16'h1111);
    ready_r = 1'b1;
    idle();
    lit("w16 drained", 16'(act_v[2]), 16'(ev[2]), 16'h0);

`ifdef S2P_PARITY_EN
    // 6: parity check
    do_reset();
    send_word(16'h0007, 8, 1'b0, 1'b0, 1'b0);
    lit("t6 good valid", 16'(act_v[0]), 16'(ev[0]), 16'h1);
    lit("t6 good perr", 16'(act_p[0]), 16'(ep[0]), 16'h0);
    idle();
    send_word(16'h0007, 8, 1'b0, 1'b0, 1'b1);
    lit("t6 bad perr", 16'(act_p[0]), 16'(ep[0]), 16'h1);
    lit("t6 bad data", act_d[0], ed[0], 16'h0007);
    idle();
    lit("t6 perr pulse", 16'(act_p[0]), 16'(ep[0]), 16'h0);
`endif

    idle();
    idle();
    armed = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
